popcount_stream_core: RTL and testbench

- AXI4-Stream datapath core of the PopulationCounter IP, directly downstream of the DMA MM2S channel.
- Counts set bits across every valid byte of a packet, up to and including TLAST.
- Emits one single-beat result packet (32-bit count, TLAST=1) toward the DMA S2MM channel.
- Sits between the DMA streams; the AXI master/slave wrappers of the IP instantiate it.

---
 rtl/popcount_pkg.sv | 47 ++++
 rtl/popcount_stream_core_if.sv | 35 +++
 rtl/popcount_lane_sum.sv | 21 ++
 rtl/popcount_stream_core.sv | 134 +++++++++++++
 tb/tb_popcount_stream_core.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount stream core.
// Holds FSM encodings, beat-count width and the saturating add.
package popcount_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACCEPT = 2'd0;
  localparam state_t ST_DRAIN  = 2'd1;
  localparam state_t ST_SEND   = 2'd2;

  localparam int SAT_W = 64;

  function automatic int beat_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic logic [SAT_W:0] sat_max(
    input int unsigned w
  );
    logic [SAT_W:0] one;
    one = {{SAT_W{1'b0}}, 1'b1};
    return (one << w) - one;
  endfunction

  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int unsigned      w
  );
    logic [SAT_W:0] s;
    logic [SAT_W:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = sat_max(w);
    return (s > m) ? m[SAT_W-1:0] : s[SAT_W-1:0];
  endfunction

  function automatic logic sat_ovf(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int unsigned      w
  );
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s > sat_max(w);
  endfunction

endpackage

// File: rtl/popcount_stream_core_if.sv
// AXI4-Stream input and result stream bundle of the core.
// master = DMA side, slave = core side.
interface popcount_stream_core_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0]   S_AXIS_TDATA;
  logic [DATA_W/8-1:0] S_AXIS_TKEEP;
  logic                S_AXIS_TVALID;
  logic                S_AXIS_TREADY;
  logic                S_AXIS_TLAST;
  logic [CNT_W-1:0]    M_AXIS_TDATA;
  logic                M_AXIS_TVALID;
  logic                M_AXIS_TREADY;
  logic                M_AXIS_TLAST;
  logic                M_AXIS_TUSER;

  modport master (
    output S_AXIS_TDATA, S_AXIS_TKEEP,
    output S_AXIS_TVALID, S_AXIS_TLAST,
    input  S_AXIS_TREADY,
    input  M_AXIS_TDATA, M_AXIS_TVALID,
    input  M_AXIS_TLAST, M_AXIS_TUSER,
    output M_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TKEEP,
    input  S_AXIS_TVALID, S_AXIS_TLAST,
    output S_AXIS_TREADY,
    output M_AXIS_TDATA, M_AXIS_TVALID,
    output M_AXIS_TLAST, M_AXIS_TUSER,
    input  M_AXIS_TREADY
  );
endinterface

// File: rtl/popcount_lane_sum.sv
// Combinational popcount of one beat, bytes gated by TKEEP.
// Registered by the parent as pipeline stage 1.
module popcount_lane_sum
  import popcount_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CW     = beat_cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] keep_i,
  output logic [CW-1:0]       cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt_o = cnt_o + CW'(data_i[i] & keep_i[i/8]);
    end
  end

endmodule

// File: rtl/popcount_stream_core.sv
// Packet popcount core: masked per-beat count, saturating
// accumulate, one single-beat result per input packet.
module popcount_stream_core
  import popcount_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 32,
  parameter int PKT_CNT_W = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  popcount_stream_core_if.slave axis,
  output logic                 BUSY,
  output logic [PKT_CNT_W-1:0] PKT_COUNT
);

  localparam int BW = beat_cnt_w(DATA_W);

  state_t               state_q, state_d;
  logic                 tready_q;
  logic [BW-1:0]        s1_q, s1_cnt;
  logic                 s1_vld_q, s1_last_q;
  logic                 done_q;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     mdata_q, mdata_d;
  logic                 mvld_q, mvld_d;
  logic                 mlast_q, mlast_d;
  logic                 muser_q, muser_d;
  logic                 busy_q, busy_d;
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
  logic                 s_hs, m_hs;

  assign s_hs = axis.S_AXIS_TVALID & tready_q;
  assign m_hs = mvld_q & axis.M_AXIS_TREADY;

  popcount_lane_sum #(
    .DATA_W(DATA_W),
    .CW    (BW)
  ) u_lane (
    .data_i(axis.S_AXIS_TDATA),
    .keep_i(axis.S_AXIS_TKEEP),
    .cnt_o (s1_cnt)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    mdata_d = mdata_q;
    mvld_d  = mvld_q;
    mlast_d = mlast_q;
    muser_d = muser_q;
    pkt_d   = pkt_q;
    busy_d  = busy_q;
    if (s1_vld_q) begin
      acc_d = CNT_W'(sat_add(SAT_W'(acc_q),
                             SAT_W'(s1_q), CNT_W));
      ovf_d = ovf_q | sat_ovf(SAT_W'(acc_q),
                              SAT_W'(s1_q), CNT_W);
    end
    if (s_hs) busy_d = 1'b1;
    unique case (1'b1)
      state_q == ST_ACCEPT: begin
        if (s_hs && axis.S_AXIS_TLAST) state_d = ST_DRAIN;
      end
      // done_q marks the edge after the last beat was folded in
      state_q == ST_DRAIN: begin
        if (done_q) begin
          mdata_d = acc_q;
          muser_d = ovf_q;
          mvld_d  = 1'b1;
          mlast_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      state_q == ST_SEND: begin
        if (m_hs) begin
          mvld_d  = 1'b0;
          mlast_d = 1'b0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b0;
          pkt_d   = pkt_q + PKT_CNT_W'(1);
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_ACCEPT;
      tready_q  <= 1'b0;
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      mdata_q   <= '0;
      mvld_q    <= 1'b0;
      mlast_q   <= 1'b0;
      muser_q   <= 1'b0;
      busy_q    <= 1'b0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tready_q  <= (state_d == ST_ACCEPT);
      s1_q      <= s_hs ? s1_cnt : '0;
      s1_vld_q  <= s_hs;
      s1_last_q <= s_hs & axis.S_AXIS_TLAST;
      done_q    <= s1_vld_q & s1_last_q;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      mdata_q   <= mdata_d;
      mvld_q    <= mvld_d;
      mlast_q   <= mlast_d;
      muser_q   <= muser_d;
      busy_q    <= busy_d;
      pkt_q     <= pkt_d;
    end
  end

  assign axis.S_AXIS_TREADY = tready_q;
  assign axis.M_AXIS_TDATA  = mdata_q;
  assign axis.M_AXIS_TVALID = mvld_q;
  assign axis.M_AXIS_TLAST  = mlast_q;
  assign axis.M_AXIS_TUSER  = muser_q;
  assign BUSY               = busy_q;
  assign PKT_COUNT          = pkt_q;

endmodule

// File: tb/tb_popcount_stream_core.sv
// Bench for popcount_stream_core: a 32-bit and an 8-bit
// counter instance driven in lockstep, checked via scoreboard.
module tb_popcount_stream_core;

  typedef struct {
    logic [31:0] e32;
    logic        u32;
    logic [7:0]  e8;
    logic        u8;
  } exp_t;

  typedef struct {
    int              n;
    logic [8:0][31:0] d;
    logic [8:0][3:0]  k;
    bit              gap;
    exp_t            e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, mready;

  logic        busy32, busy8;
  logic [15:0] pc32, pc8;

  popcount_stream_core_if #(.DATA_W(32), .CNT_W(32)) ax32 ();
  popcount_stream_core_if #(.DATA_W(32), .CNT_W(8))  ax8 ();

  assign ax32.S_AXIS_TDATA  = tdata;
  assign ax32.S_AXIS_TKEEP  = tkeep;
  assign ax32.S_AXIS_TVALID = tvalid;
  assign ax32.S_AXIS_TLAST  = tlast;
  assign ax32.M_AXIS_TREADY = mready;
  assign ax8.S_AXIS_TDATA   = tdata;
  assign ax8.S_AXIS_TKEEP   = tkeep;
  assign ax8.S_AXIS_TVALID  = tvalid;
  assign ax8.S_AXIS_TLAST   = tlast;
  assign ax8.M_AXIS_TREADY  = mready;

  popcount_stream_core #(
    .DATA_W(32), .CNT_W(32), .PKT_CNT_W(16)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .axis(ax32),
    .BUSY(busy32), .PKT_COUNT(pc32)
  );

  popcount_stream_core #(
    .DATA_W(32), .CNT_W(8), .PKT_CNT_W(16)
  ) dut8 (
    .ACLK(clk), .ARESETN(rst_n), .axis(ax8),
    .BUSY(busy8), .PKT_COUNT(pc8)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t v[7];
  int exp_pkt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_ctl32", 32'({ax32.S_AXIS_TREADY, ax32.M_AXIS_TVALID,
        ax32.M_AXIS_TLAST, ax32.M_AXIS_TUSER, busy32}), 32'd0);
    chk("rst_data32", ax32.M_AXIS_TDATA, 32'd0);
    chk("rst_pkt32", 32'(pc32), 32'd0);
    chk("rst_ctl8", 32'({ax8.S_AXIS_TREADY, ax8.M_AXIS_TVALID,
        ax8.M_AXIS_TLAST, ax8.M_AXIS_TUSER, busy8}), 32'd0);
    chk("rst_data8", 32'(ax8.M_AXIS_TDATA), 32'd0);
    chk("rst_pkt8", 32'(pc8), 32'd0);
  endtask

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(ax32.M_AXIS_TVALID), 32'd1);
        chk("hold_data", ax32.M_AXIS_TDATA, pd);
      end
      if (ax32.M_AXIS_TVALID && mready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(ax32.M_AXIS_TVALID), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("tdata32", ax32.M_AXIS_TDATA, e.e32);
          chk("tuser32", 32'(ax32.M_AXIS_TUSER), 32'(e.u32));
          chk("tlast32", 32'(ax32.M_AXIS_TLAST), 32'd1);
          chk("tvalid8", 32'(ax8.M_AXIS_TVALID), 32'd1);
          chk("tdata8", 32'(ax8.M_AXIS_TDATA), 32'(e.e8));
          chk("tuser8", 32'(ax8.M_AXIS_TUSER), 32'(e.u8));
        end
      end
    end
    pv = rst_n && ax32.M_AXIS_TVALID;
    pr = mready;
    pd = ax32.M_AXIS_TDATA;
  end

  task automatic drive_beat(input logic [31:0] d,
                            input logic [3:0] k,
                            input logic l,
                            input bit need_rdy);
    int g;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    @(negedge clk);
    if (need_rdy)
      chk("no_bubble", 32'(ax32.S_AXIS_TREADY), 32'd1);
    g = 0;
    while (!ax32.S_AXIS_TREADY && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!ax32.S_AXIS_TREADY)
      chk("accept_timeout", 32'(ax32.S_AXIS_TREADY), 32'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int i);
    for (int b = 0; b < v[i].n; b++) begin
      if (b == 1 && v[i].gap) begin
        @(posedge clk);
        #1;
      end
      drive_beat(v[i].d[b], v[i].k[b],
                 logic'(b == v[i].n - 1), b != 0);
    end
  endtask

  initial begin
    int g;
    tdata  = '0;
    tkeep  = '0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    mready = 1'b1;

    for (int i = 0; i < 7; i++) begin
      v[i].n   = 1;
      v[i].d   = '0;
      v[i].k   = {9{4'hF}};
      v[i].gap = 1'b0;
    end
    v[0].n = 3;
    v[0].d[0] = 32'h0000_0001;
    v[0].d[1] = 32'h8000_0001;
    v[0].d[2] = 32'hF0F0_F0F0;
    v[0].e = '{32'd19, 1'b0, 8'd19, 1'b0};
    v[1].d[0] = 32'hFFFF_FFFF;
    v[1].k[0] = 4'h3;
    v[1].e = '{32'd16, 1'b0, 8'd16, 1'b0};
    v[2].d[0] = 32'hDEAD_BEEF;
    v[2].k[0] = 4'h0;
    v[2].e = '{32'd0, 1'b0, 8'd0, 1'b0};
    v[3].n = 9;
    v[3].d = {9{32'hFFFF_FFFF}};
    v[3].e = '{32'd288, 1'b0, 8'd255, 1'b1};
    v[4].d[0] = 32'h0000_0001;
    v[4].e = '{32'd1, 1'b0, 8'd1, 1'b0};
    v[5].n = 2;
    v[5].gap = 1'b1;
    v[5].d[0] = 32'h0000_00FF;
    v[5].d[1] = 32'h0000_0F00;
    v[5].e = '{32'd12, 1'b0, 8'd12, 1'b0};
    v[6].n = 2;
    v[6].d[0] = 32'hFFFF_FFFF;
    v[6].k[0] = 4'b1000;
    v[6].d[1] = 32'hFFFF_FFFF;
    v[6].k[1] = 4'b0101;
    v[6].e = '{32'd24, 1'b0, 8'd24, 1'b0};

    repeat (2) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_rst", 32'(ax32.S_AXIS_TREADY), 32'd1);

    // latency of a single-beat packet, edge by edge
    sb.push_back('{32'd32, 1'b0, 8'd32, 1'b0});
    drive_beat(32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_k_valid", 32'(ax32.M_AXIS_TVALID), 32'd0);
    chk("lat_k_tready", 32'(ax32.S_AXIS_TREADY), 32'd0);
    chk("lat_k_busy", 32'(busy32), 32'd1);
    @(negedge clk);
    chk("lat_k1_valid", 32'(ax32.M_AXIS_TVALID), 32'd0);
    @(negedge clk);
    chk("lat_k2_valid", 32'(ax32.M_AXIS_TVALID), 32'd1);
    @(negedge clk);
    chk("lat_k3_valid", 32'(ax32.M_AXIS_TVALID), 32'd0);
    chk("lat_k3_tready", 32'(ax32.S_AXIS_TREADY), 32'd1);
    chk("lat_k3_busy", 32'(busy32), 32'd0);
    exp_pkt = 1;
    chk("lat_pkt", 32'(pc32), 32'(exp_pkt));
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      sb.push_back(v[i].e);
      send_vec(i);
      wait_done();
      exp_pkt++;
      chk("pkt_count32", 32'(pc32), 32'(exp_pkt));
      chk("pkt_count8", 32'(pc8), 32'(exp_pkt));
    end

    // result backpressure
    mready = 1'b0;
    sb.push_back('{32'd16, 1'b0, 8'd16, 1'b0});
    drive_beat(32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0);
    g = 0;
    while (!ax32.M_AXIS_TVALID && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("bp_valid_rise", 32'(ax32.M_AXIS_TVALID), 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 32'(ax32.M_AXIS_TVALID), 32'd1);
      chk("bp_tready", 32'(ax32.S_AXIS_TREADY), 32'd0);
      chk("bp_data", ax32.M_AXIS_TDATA, 32'd16);
      chk("bp_user", 32'(ax32.M_AXIS_TUSER), 32'd0);
    end
    @(posedge clk);
    #1;
    mready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_after_valid", 32'(ax32.M_AXIS_TVALID), 32'd0);
    chk("bp_after_tready", 32'(ax32.S_AXIS_TREADY), 32'd1);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    exp_pkt++;
    chk("bp_pkt", 32'(pc32), 32'(exp_pkt));

    // reset in the middle of a four-beat packet
    drive_beat(32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
    drive_beat(32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1);
    chk("mid_busy", 32'(busy32), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
    exp_pkt = 0;
    @(posedge clk);
    #1;
    chk("rst2_tready", 32'(ax32.S_AXIS_TREADY), 32'd1);
    sb.push_back('{32'd2, 1'b0, 8'd2, 1'b0});
    drive_beat(32'h0000_0003, 4'hF, 1'b1, 1'b0);
    wait_done();
    exp_pkt++;
    chk("rst2_pkt32", 32'(pc32), 32'(exp_pkt));
    chk("rst2_pkt8", 32'(pc8), 32'(exp_pkt));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
